// File: rtl/fetch_pipe_ctrl.sv
// WISC fetch front end: PC register, instruction-memory request handshake and
// IF/ID pipeline register, steered by the hazard unit's stall/flush/redirect.
module fetch_pipe_ctrl #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]         HLT_OPC   = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_wen,
    input  logic               if_id_wen,
    input  logic               if_id_flush,
    input  logic               control_hazard,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc2,
    output logic               if_id_valid,
    output logic               fetch_stall,
    output logic               halted
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc2;
    } fetch_ent_t;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
    fetch_ent_t        hold_buf, hold_nxt;
    logic              redir_pend, redir_pend_nxt;
    logic [ADDR_W-1:0] redir_tgt, redir_tgt_nxt;
    logic              ld_vld;
    fetch_ent_t        ld_ent;
    logic              adv;

    assign pc_inc      = pc + ADDR_W'(2);
    assign adv         = pc_wen && if_id_wen;
    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = pc;
    assign fetch_stall = (state == ST_REQ) && !imem_valid;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_nxt       = hold_buf;
        redir_pend_nxt = redir_pend;
        redir_tgt_nxt  = redir_tgt;
        ld_vld         = 1'b0;
        ld_ent         = {imem_rdata, pc_inc};
        case (state)
            ST_REQ: begin
                if (imem_valid) begin
                    // A redirect arriving with the response makes that response wrong-path.
                    if (control_hazard) begin
                        pc_nxt         = branch_target;
                        redir_pend_nxt = 1'b0;
                    end else if (redir_pend) begin
                        pc_nxt         = redir_tgt;
                        redir_pend_nxt = 1'b0;
                    end else if (adv) begin
                        ld_vld = 1'b1;
                        pc_nxt = pc_inc;
                    end else begin
                        hold_nxt  = {imem_rdata, pc_inc};
                        state_nxt = ST_HOLD;
                    end
                end else if (control_hazard) begin
                    redir_pend_nxt = 1'b1;
                    redir_tgt_nxt  = branch_target;
                end
            end
            ST_HOLD: begin
                ld_ent = hold_buf;
                if (control_hazard) begin
                    pc_nxt    = branch_target;
                    state_nxt = ST_REQ;
                end else if (adv) begin
                    ld_vld    = 1'b1;
                    pc_nxt    = pc_inc;
                    state_nxt = ST_REQ;
                end
            end
            ST_HALT: begin
                if (control_hazard) begin
                    pc_nxt    = branch_target;
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase
        if (ld_vld && !if_id_flush && ld_ent.instr[INSTR_W-1 -: 4] == HLT_OPC)
            state_nxt = ST_HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            hold_buf   <= '0;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_buf   <= hold_nxt;
            redir_pend <= redir_pend_nxt;
            redir_tgt  <= redir_tgt_nxt;
            halted     <= (state_nxt == ST_HALT);
        end
    end

    // Advancing with nothing to load inserts a bubble; HALT pins the HLT in IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc2   <= '0;
            if_id_valid <= 1'b0;
        end else if (if_id_flush) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (if_id_wen && state != ST_HALT) begin
            if (ld_vld) begin
                if_id_instr <= ld_ent.instr;
                if_id_pc2   <= ld_ent.pc2;
                if_id_valid <= 1'b1;
            end else begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
- Front end of the WISC pipeline.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the stall, flush and redirect controls issued by the hazard detection unit (pc_wen, if_id_wen, if_id_flush, control_hazard).
- Reports its own memory-wait stall back to the hazard detection unit.

Parameters:
ADDR_W, 16, PC / instruction address width
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value after reset
NOP_INSTR, 16'h0000, bubble inserted on flush
HLT_OPC, 4'hF, opcode that halts fetch

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pc_wen  in  1  PC write enable from hazard unit; 0 = hold PC
if_id_wen  in  1  IF/ID write enable; 0 = hold IF/ID contents
if_id_flush  in  1  squash IF/ID to bubble
control_hazard  in  1  redirect strobe; PC takes branch_target
branch_target  in  ADDR_W  redirect address
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= PC)
imem_valid  in  1  fetch response valid
imem_rdata  in  INSTR_W  fetched instruction
if_id_instr  out  INSTR_W  decode-stage instruction
if_id_pc2  out  ADDR_W  PC+2 of that instruction
if_id_valid  out  1  IF/ID holds a real instruction
fetch_stall  out  1  front end waiting on memory
halted  out  1  HLT reached decode; fetch stopped

Behaviour:
- Reset (async, any cycle, including mid-request):
  - PC=RESET_PC; state=REQ; if_id_instr=NOP_INSTR; if_id_pc2=0; if_id_valid=0; halted=0.
  - Hold buffer empty; redirect-pending flag clear; any in-flight response forgotten.
- States: REQ, HOLD, HALT.
- REQ:
  - imem_req=1; imem_addr=PC, held stable until imem_valid.
  - fetch_stall=1 while imem_valid=0.
  - On imem_valid with no redirect pending:
    - if_id_wen=1 and pc_wen=1: IF/ID <= {imem_rdata, PC+2, valid=1}; PC <= PC+2; stay in REQ (one instruction per cycle with a zero-wait memory).
    - Otherwise: capture {rdata, PC+2} in the hold buffer; go to HOLD.
- HOLD:
  - imem_req=0; fetch_stall=0.
  - Once if_id_wen=1 and pc_wen=1 in the same cycle: buffer -> IF/ID; PC <= PC+2; go to REQ.
- Redirect (control_hazard=1):
  - No request outstanding (HOLD, or REQ with imem_valid=1): PC <= branch_target next cycle; hold buffer discarded; go to REQ. Redirect overrides pc_wen=0.
  - REQ with imem_valid=0: set the redirect-pending flag and latch the target. The next response is discarded (not written to IF/ID); then PC <= latched target; flag cleared; stay in REQ.
  - A second redirect while one is pending overwrites the latched target.
- IF/ID priority, highest first: rst > if_id_flush > if_id_wen=0 (hold) > load.
  - Flush: if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc2 unchanged.
  - Flush does not by itself move the PC.
- Halt:
  - An instruction with opcode HLT_OPC loaded into IF/ID (not flushed in that cycle) sends the FSM to HALT.
  - HALT: imem_req=0; PC frozen; halted=1; IF/ID holds the HLT.
  - control_hazard in HALT: halted=0; PC <= branch_target; go to REQ. This covers a taken branch older than the HLT.
  - if_id_flush in HALT: squashes the HLT but does not leave HALT.
- PC arithmetic: ADDR_W-bit, wraps 16'hFFFE -> 16'h0000 with no error.
- Outputs: all registered except imem_req, imem_addr and fetch_stall, which decode from state/PC.

Test Plan:
- Zero-wait stream: reset, imem_valid tied 1, rdata = addr -> if_id_pc2 = 2,4,6 in consecutive cycles; if_id_instr lags by one; if_id_valid=1 from cycle 2.
- Stall: pc_wen=if_id_wen=0 for 3 cycles at PC=0x0006 -> IF/ID frozen; state HOLD; imem_req=0; on release, instruction 0x0006 loads and PC=0x0008.
- Wait-state redirect: memory delays 3 cycles at PC=0x0010; control_hazard with target 0x0040 in delay cycle 1 -> 0x0010 response dropped; next imem_addr=0x0040; if_id_valid never shows 0x0010.
- Flush vs load: if_id_flush=1 with imem_valid=1 -> if_id_instr=0x0000, if_id_valid=0; PC still advances by 2.
- Halt: fetch 0xF000 at 0x0020 -> halted=1, imem_req=0, PC=0x0022 frozen; control_hazard to 0x0100 -> halted=0, imem_addr=0x0100.
- Async reset asserted mid-wait at PC=0x0FFE -> outputs at reset values immediately; PC=0x0000 with no clock edge.
